// File: rtl/risc_boot_ctrl_pkg.sv
// Shared definitions for the risc boot loader: FSM state encodings and
// frame constants used by the controller and its byte packer.
package risc_boot_ctrl_pkg;

    // Number of host bytes that make up one instruction word.
    localparam int WORD_BYTES = 4;

    // Loader FSM states (3-bit encoding).
    typedef enum logic [2:0] {
        ST_LEN0 = 3'd0,
        ST_LEN1 = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_RUN  = 3'd4,
        ST_ERR  = 3'd5
    } boot_state_e;

    // True while a frame is being received; drives busy and in_ready.
    function automatic logic is_loading(input boot_state_e s);
        return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/risc_boot_ctrl_packer.sv
// Little-endian byte-to-word packer: collects three bytes in a shift
// register and presents the full word combinationally with the fourth byte.
module risc_boot_ctrl_packer
    import risc_boot_ctrl_pkg::*;
(
    input  logic        clk_i,
    input  logic        clr_i,
    input  logic [7:0]  byte_i,
    input  logic        valid_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [23:0] shift_q;
    logic [1:0]  idx_q;

    // The first byte of a word ends up in bits [7:0] once three bytes are held.
    assign word_o       = {byte_i, shift_q};
    assign word_valid_o = valid_i & (idx_q == 2'(WORD_BYTES - 1));

    // Shift register and byte index; clr_i covers both reset and reload.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            shift_q <= 24'h000000;
            idx_q   <= 2'd0;
        end else if (valid_i) begin
            shift_q <= {byte_i, shift_q[23:8]};
            idx_q   <= idx_q + 2'd1;
        end else begin
            shift_q <= shift_q;
            idx_q   <= idx_q;
        end
    end

endmodule

// File: rtl/risc_boot_ctrl.sv
// Boot loader for the risc core: keeps the core in clear, receives a
// length-prefixed byte frame, writes packed words to imem from address 0,
// verifies an XOR checksum and then releases the core.
module risc_boot_ctrl #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_req,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              err
);
    import risc_boot_ctrl_pkg::*;

    localparam int DEPTH = 2 ** ADDR_W;

    boot_state_e       state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  word_cnt_q, word_cnt_d;
    logic [7:0]        csum_q, csum_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              core_rst_q, core_rst_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic              xfer_s;
    logic              data_xfer_s;
    logic              pack_clr_s;
    logic [31:0]       word_s;
    logic              word_valid_s;
    logic [LEN_W-1:0]  len_full_s;

    // A byte that arrives together with load_req never reaches the packer.
    assign xfer_s      = in_valid & in_ready_q;
    assign data_xfer_s = xfer_s & (state_q == ST_DATA) & ~load_req;
    assign pack_clr_s  = rst_n | load_req;
    assign len_full_s  = {in_data, len_q[7:0]};

    risc_boot_ctrl_packer u_packer (
        .clk_i        (clk),
        .clr_i        (pack_clr_s),
        .byte_i       (in_data),
        .valid_i      (data_xfer_s),
        .word_o       (word_s),
        .word_valid_o (word_valid_s)
    );

    // Next-state and next-output logic for the loader FSM.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        word_cnt_d   = word_cnt_q;
        csum_d       = csum_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;

        if (load_req) begin
            state_d    = ST_LEN0;
            len_d      = '0;
            word_cnt_d = '0;
            csum_d     = 8'h00;
        end else begin
            case (state_q)
                ST_LEN0: begin
                    if (xfer_s) begin
                        len_d   = {{(LEN_W-8){1'b0}}, in_data};
                        state_d = ST_LEN1;
                    end else begin
                        state_d = ST_LEN0;
                    end
                end
                ST_LEN1: begin
                    if (xfer_s) begin
                        len_d = len_full_s;
                        if (len_full_s == '0) begin
                            state_d = ST_CSUM;
                        end else if (len_full_s > LEN_W'(DEPTH)) begin
                            state_d = ST_ERR;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        state_d = ST_LEN1;
                    end
                end
                ST_DATA: begin
                    if (data_xfer_s) begin
                        csum_d = csum_q ^ in_data;
                    end else begin
                        csum_d = csum_q;
                    end
                    if (word_valid_s) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = word_cnt_q[ADDR_W-1:0];
                        imem_wdata_d = word_s;
                        word_cnt_d   = word_cnt_q + LEN_W'(1);
                        if ((word_cnt_q + LEN_W'(1)) == len_q) begin
                            state_d = ST_CSUM;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_CSUM: begin
                    if (xfer_s) begin
                        state_d = (in_data == csum_q) ? ST_RUN : ST_ERR;
                    end else begin
                        state_d = ST_CSUM;
                    end
                end
                ST_RUN:  state_d = ST_RUN;
                ST_ERR:  state_d = ST_ERR;
                default: state_d = ST_ERR;
            endcase
        end

        // Outputs follow the state being entered so they are registered with it.
        core_rst_d = (state_d != ST_RUN);
        busy_d     = is_loading(state_d);
        in_ready_d = is_loading(state_d);
        err_d      = (state_d == ST_ERR);
    end

    // State, counter, checksum and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q      <= ST_LEN0;
            len_q        <= '0;
            word_cnt_q   <= '0;
            csum_q       <= 8'h00;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 32'h00000000;
            core_rst_q   <= 1'b1;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_cnt_q   <= word_cnt_d;
            csum_q       <= csum_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_rst_q   <= core_rst_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_rst   = core_rst_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_risc_boot_ctrl.sv
// Directed bench for risc_boot_ctrl: frames are pushed byte by byte and
// imem writes are collected by a monitor for comparison with hand values.
module tb_risc_boot_ctrl;

    logic        clk;
    logic        rst_n;
    logic        load_req;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        busy;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  wr_addr_q [$];
    logic [31:0] wr_data_q [$];

    risc_boot_ctrl #(.ADDR_W(8), .LEN_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_req   (load_req),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .busy       (busy),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record every imem write in the middle of its cycle.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Offer one byte and return on the negedge after it was accepted.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            chk("xfer_timeout", 32'(in_ready), 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_load;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic clear_log;
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    initial begin
        logic [7:0] t4 [16];
        rst_n    = 1'b1;
        load_req = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        idle(3);

        // Reset values
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy",     32'(busy),     32'd1);
        chk("rst_err",      32'(err),      32'd0);
        chk("rst_we",       32'(imem_we),  32'd0);
        chk("rst_addr",     32'(imem_addr), 32'd0);
        chk("rst_wdata",    imem_wdata,    32'h00000000);
        rst_n = 1'b0;
        idle(1);

        // Test 1: two-word frame, checksum 13^93^10 = 0x90
        clear_log();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        chk("t1_we0",    32'(imem_we),   32'd1);
        chk("t1_addr0",  32'(imem_addr), 32'd0);
        chk("t1_data0",  imem_wdata,     32'h00000013);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        chk("t1_we1",    32'(imem_we),   32'd1);
        chk("t1_addr1",  32'(imem_addr), 32'd1);
        chk("t1_data1",  imem_wdata,     32'h00100093);
        chk("t1_core_rst_pre", 32'(core_rst), 32'd1);
        send_byte(8'h90);
        chk("t1_core_rst", 32'(core_rst), 32'd0);
        chk("t1_busy",     32'(busy),     32'd0);
        chk("t1_in_ready", 32'(in_ready), 32'd0);
        chk("t1_err",      32'(err),      32'd0);
        chk("t1_nwr",      32'(wr_addr_q.size()), 32'd2);

        // Test 2: same frame, bad checksum
        pulse_load();
        chk("t2_reload_core_rst", 32'(core_rst), 32'd1);
        chk("t2_reload_busy",     32'(busy),     32'd1);
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        send_byte(8'h81);
        chk("t2_err",      32'(err),      32'd1);
        chk("t2_core_rst", 32'(core_rst), 32'd1);
        chk("t2_in_ready", 32'(in_ready), 32'd0);
        chk("t2_busy",     32'(busy),     32'd0);
        pulse_load();
        chk("t2_clr_err",      32'(err),      32'd0);
        chk("t2_clr_in_ready", 32'(in_ready), 32'd1);
        chk("t2_clr_busy",     32'(busy),     32'd1);

        // Test 3: length 257 exceeds depth
        clear_log();
        send_byte(8'h01); send_byte(8'h01);
        chk("t3_err",      32'(err),      32'd1);
        chk("t3_in_ready", 32'(in_ready), 32'd0);
        in_data  = 8'h55;
        in_valid = 1'b1;
        idle(6);
        in_valid = 1'b0;
        chk("t3_nwr",      32'(wr_addr_q.size()), 32'd0);
        chk("t3_core_rst", 32'(core_rst), 32'd1);

        // Test 4: N=4 with idle gaps; checksum 0x44^0x00^0x22^0x01 = 0x67
        pulse_load();
        clear_log();
        t4 = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hA5, 8'hA5, 8'hA5, 8'hA5,
               8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h01, 8'h00, 8'h00, 8'h00};
        send_byte(8'h04); send_byte(8'h00);
        for (int i = 0; i < 16; i++) begin
            idle($urandom_range(1, 3));
            send_byte(t4[i]);
        end
        idle(2);
        send_byte(8'h67);
        chk("t4_nwr",      32'(wr_addr_q.size()), 32'd4);
        if (wr_addr_q.size() == 4) begin
            chk("t4_a0", 32'(wr_addr_q[0]), 32'd0); chk("t4_d0", wr_data_q[0], 32'h11223344);
            chk("t4_a1", 32'(wr_addr_q[1]), 32'd1); chk("t4_d1", wr_data_q[1], 32'hA5A5A5A5);
            chk("t4_a2", 32'(wr_addr_q[2]), 32'd2); chk("t4_d2", wr_data_q[2], 32'hDEADBEEF);
            chk("t4_a3", 32'(wr_addr_q[3]), 32'd3); chk("t4_d3", wr_data_q[3], 32'h00000001);
        end
        chk("t4_core_rst", 32'(core_rst), 32'd0);
        chk("t4_err",      32'(err),      32'd0);

        // Test 5: load_req together with third data byte; checksum 78^56^34^12 = 0x08
        pulse_load();
        clear_log();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB);
        in_data  = 8'hCC;
        in_valid = 1'b1;
        load_req = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        load_req = 1'b0;
        chk("t5_busy",     32'(busy),     32'd1);
        chk("t5_in_ready", 32'(in_ready), 32'd1);
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        send_byte(8'h08);
        chk("t5_nwr", 32'(wr_addr_q.size()), 32'd1);
        if (wr_addr_q.size() == 1) begin
            chk("t5_a0", 32'(wr_addr_q[0]), 32'd0);
            chk("t5_d0", wr_data_q[0], 32'h12345678);
        end
        chk("t5_core_rst", 32'(core_rst), 32'd0);
        chk("t5_err",      32'(err),      32'd0);

        // Test 6: empty frame, then reload from RUN
        pulse_load();
        clear_log();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        chk("t6_core_rst", 32'(core_rst), 32'd0);
        chk("t6_busy",     32'(busy),     32'd0);
        chk("t6_nwr",      32'(wr_addr_q.size()), 32'd0);
        pulse_load();
        chk("t6_reload_core_rst", 32'(core_rst), 32'd1);
        chk("t6_reload_busy",     32'(busy),     32'd1);

        // Test 7: N = DEPTH = 256, word i = i; XOR of 0..255 is 0x00
        clear_log();
        send_byte(8'h00); send_byte(8'h01);
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i)); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        end
        send_byte(8'h00);
        chk("t7_nwr", 32'(wr_addr_q.size()), 32'd256);
        if (wr_addr_q.size() == 256) begin
            for (int i = 0; i < 256; i++) begin
                chk("t7_addr", 32'(wr_addr_q[i]), 32'(i));
                chk("t7_data", wr_data_q[i], 32'(i));
            end
        end
        chk("t7_core_rst", 32'(core_rst), 32'd0);
        chk("t7_err",      32'(err),      32'd0);

        // Reset wins over a simultaneous load_req
        rst_n    = 1'b1;
        load_req = 1'b1;
        @(negedge clk);
        rst_n    = 1'b0;
        load_req = 1'b0;
        chk("rst2_core_rst", 32'(core_rst), 32'd1);
        chk("rst2_busy",     32'(busy),     32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
